kdw_tile_buffer: RTL and testbench
==================================

// Module: kdw_tile_buffer
// PURPOSE
//  Ping-pong kernel-tile buffer for depthwise (DW) convolution. One bank is filled
//  element-by-element from the loader; the other is read by the DW PE array,
//  returning N_CH channel weights per row. A swap makes a fully loaded bank readable.
//  Sits between the weight-load DMA and the DW compute array.
// PARAMETERS
//  WG_W   8   weight element width (bits)
//  N_CH   4   channels per row = parallel read lanes
//  DEPTH  9   rows per bank (kernel positions, e.g. 3x3)
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous reset, active low
//  ld_start   in   1            pulse: begin loading fill bank (accepted in IDLE only)
//  ld_valid   in   1            load element valid
//  ld_data    in   WG_W         load element; row-major order: row r, lane 0..N_CH-1
//  ld_last    in   1            early end of tile (only with KDW_ZERO_PAD_EN)
//  ld_ready   out  1            buffer accepts element (state LOAD)
//  fill_full  out  1            fill bank completely loaded (state FULL)
//  swap       in   1            pulse: exchange fill and read banks
//  swap_err   out  1            1-cycle pulse: swap rejected (fill bank not FULL)
//  rd_bank_ok out  1            read bank holds a valid tile
//  rd_en      in   1            read request
//  rd_addr    in   $clog2(DEPTH) row to read
//  rd_data    out  N_CH*WG_W    row data, lane i at [i*WG_W +: WG_W]
//  rd_valid   out  1            rd_data valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): fill FSM=IDLE, bank pointer=0, row/lane counters=0,
//    ld_ready=0, fill_full=0, swap_err=0, rd_bank_ok=0, rd_valid=0, rd_data=0.
//    Memory contents not cleared. Reset mid-load abandons the partial tile.
//  - Fill FSM: IDLE -ld_start-> LOAD -last beat-> FULL -swap-> IDLE.
//    ld_start outside IDLE ignored. ld_ready=1 exactly in LOAD.
//  - Beat = ld_valid&&ld_ready: write ld_data to fill bank row cnt_row lane cnt_lane;
//    lane increments, wraps at N_CH-1 to 0 with row+1. Beat at row DEPTH-1,
//    lane N_CH-1 -> FULL next cycle; counters return to 0.
//  - swap in FULL: bank pointer toggles, fill FSM->IDLE, rd_bank_ok=1, next cycle.
//    swap in IDLE/LOAD: no change, swap_err=1 for one cycle.
//    swap and rd_en same cycle: the read is serviced from the pre-swap read bank.
//  - Read: rd_en sampled at edge N -> rd_data/rd_valid at edge N+1 (1-cycle latency,
//    fully pipelined, one read per cycle). rd_valid=0 when rd_en=0; rd_data holds.
//    rd_en with rd_addr>=DEPTH: rd_valid=1, rd_data=0. rd_en with rd_bank_ok=0:
//    rd_valid=1, data undefined (caller's error; no flag).
//  - Fill and read banks are always distinct: no read/write collision possible.
// CONFIGURATION
//  KDW_ZERO_PAD_EN defined: ld_last on a beat ends the tile -> FULL; per-bank stored
//   row count = last row written + 1 (partial row: lanes not written read as 0).
//   Reads at rows >= count return 0. Count latched with the tile, follows the swap.
//  Undefined: ld_last ignored; every tile is exactly DEPTH*N_CH beats; no count logic.
// TESTING (WG_W=8, N_CH=4, DEPTH=9)
//  1 Reset -> all outputs 0; ld_start, 36 beats data=k (k=0..35), swap, read rows
//    0..8 back-to-back -> row r = {4r+3,4r+2,4r+1,4r}, rd_valid every cycle, lat 1.
//  2 swap after 20 beats -> swap_err pulse 1 cycle, state stays LOAD, rd_bank_ok=0.
//  3 Load tile B while reading tile A each cycle -> A reads unaffected; swap,
//    then reads return B; swap+rd_en same cycle returns A.
//  4 ld_valid gapped (1 of 3 cycles) -> fill_full only after 36th accepted beat.
//  5 rst_n low at beat 17 -> outputs 0 async; new ld_start loads full tile correctly.
//  6 KDW_ZERO_PAD_EN: ld_last on beat 10 (row 2 lane 1), swap -> row 2 = {0,0,d9,d8},
//    rows 3..8 = 0; read rd_addr=9 -> rd_valid=1, data 0.

Source files
------------

// File: rtl/kdw_tile_buffer_if.sv
// Load, swap and read channels of the DW kernel-tile ping-pong buffer.
// master: loader / PE-array side; slave: kdw_tile_buffer.
//   ld_start/ld_valid/ld_data/ld_last -> load request, ld_ready/fill_full <- status
//   swap -> bank exchange, swap_err/rd_bank_ok <- status
//   rd_en/rd_addr -> row read, rd_data/rd_valid <- row result (1-cycle latency)
interface kdw_tile_buffer_if #(
   parameter int WG_W  = 8,
   parameter int N_CH  = 4,
   parameter int DEPTH = 9
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                 ld_start;
   logic                 ld_valid;
   logic [WG_W-1:0]      ld_data;
   logic                 ld_last;
   logic                 ld_ready;
   logic                 fill_full;
   logic                 swap;
   logic                 swap_err;
   logic                 rd_bank_ok;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic [N_CH*WG_W-1:0] rd_data;
   logic                 rd_valid;

   modport master (
      output ld_start, ld_valid, ld_data, ld_last,
      output swap, rd_en, rd_addr,
      input  ld_ready, fill_full, swap_err,
      input  rd_bank_ok, rd_data, rd_valid
   );

   modport slave (
      input  ld_start, ld_valid, ld_data, ld_last,
      input  swap, rd_en, rd_addr,
      output ld_ready, fill_full, swap_err,
      output rd_bank_ok, rd_data, rd_valid
   );
endinterface

// File: rtl/kdw_tile_buffer.sv
// Ping-pong kernel-tile buffer for depthwise convolution: one bank is filled
// element by element from the weight loader while the other is read by the
// DW PE array, N_CH channel weights per row. swap makes a loaded bank readable.
// Ports: clk, rst_n (async, active low), bus (kdw_tile_buffer_if.slave).
// Option: define KDW_ZERO_PAD_EN to let ld_last end a tile early; rows and
// lanes past the last written element then read back as zero.
module kdw_tile_buffer #(
   parameter int WG_W  = 8,
   parameter int N_CH  = 4,
   parameter int DEPTH = 9
) (
   input logic              clk,
   input logic              rst_n,
   kdw_tile_buffer_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RW = N_CH * WG_W;

   localparam logic [AW-1:0] LAST_ROW  = AW'(DEPTH - 1);
   localparam logic [LW-1:0] LAST_LANE = LW'(N_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FULL
   } state_t;

   state_t        state;
   state_t        state_nx;

   // bank_ptr selects the read bank; the fill bank is always the other one
   logic          bank_ptr;
   logic          fill_bank;
   logic [AW-1:0] cnt_row;
   logic [LW-1:0] cnt_lane;

   logic          beat;
   logic          end_pos;
   logic          tile_done;
   logic          swap_ok;
   logic          swap_bad;

   logic [RW-1:0] mem [2][DEPTH];

   logic          rd_in_range;
   logic [AW-1:0] rd_row_idx;
   logic [RW-1:0] rd_row;
   logic [RW-1:0] rd_next;

   assign fill_bank = ~bank_ptr;
   assign end_pos   = (cnt_row == LAST_ROW) && (cnt_lane == LAST_LANE);

`ifdef KDW_ZERO_PAD_EN
   assign tile_done = beat && (end_pos || bus.ld_last);
`else
   logic unused_ld_last;
   assign unused_ld_last = bus.ld_last;
   assign tile_done      = beat && end_pos;
`endif

   // ---------------- fill FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (bus.ld_start) state_nx = S_LOAD;
         S_LOAD:  if (tile_done) state_nx = S_FULL;
         S_FULL:  if (bus.swap) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ld_ready  = 1'b0;
      bus.fill_full = 1'b0;
      swap_ok       = 1'b0;
      swap_bad      = 1'b0;
      unique case (state)
         S_IDLE: swap_bad = bus.swap;
         S_LOAD: begin
            bus.ld_ready = 1'b1;
            swap_bad     = bus.swap;
         end
         S_FULL: begin
            bus.fill_full = 1'b1;
            swap_ok       = bus.swap;
         end
         default: swap_bad = bus.swap;
      endcase
   end

   assign beat = bus.ld_valid && bus.ld_ready;

   // ---------------- element counters ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_row  <= '0;
         cnt_lane <= '0;
      end else if (tile_done) begin
         cnt_row  <= '0;
         cnt_lane <= '0;
      end else if (beat) begin
         if (cnt_lane == LAST_LANE) begin
            cnt_lane <= '0;
            cnt_row  <= cnt_row + 1'b1;
         end else begin
            cnt_lane <= cnt_lane + 1'b1;
         end
      end
   end

   // ---------------- bank control ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_ptr       <= 1'b0;
         bus.rd_bank_ok <= 1'b0;
         bus.swap_err   <= 1'b0;
      end else begin
         bus.swap_err <= swap_bad;
         if (swap_ok) begin
            bank_ptr       <= ~bank_ptr;
            bus.rd_bank_ok <= 1'b1;
         end
      end
   end

   // ---------------- storage (never cleared) ----------------
   always_ff @(posedge clk) begin
      if (beat) begin
         for (int i = 0; i < N_CH; i++) begin
            if (cnt_lane == LW'(i)) begin
               mem[fill_bank][cnt_row][i*WG_W +: WG_W] <= bus.ld_data;
            end
         end
      end
   end

`ifdef KDW_ZERO_PAD_EN
   // Position of the last element written per physical bank; it travels
   // with the bank, so it follows the tile through a swap.
   logic [AW-1:0] ext_row  [2];
   logic [LW-1:0] ext_lane [2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            ext_row[b]  <= LAST_ROW;
            ext_lane[b] <= LAST_LANE;
         end
      end else if (tile_done) begin
         ext_row[fill_bank]  <= cnt_row;
         ext_lane[fill_bank] <= cnt_lane;
      end
   end
`endif

   // ---------------- read path ----------------
   always_comb begin
      rd_in_range = (bus.rd_addr <= LAST_ROW);
      rd_row_idx  = rd_in_range ? bus.rd_addr : '0;
      rd_row      = mem[bank_ptr][rd_row_idx];
      rd_next     = rd_in_range ? rd_row : '0;
`ifdef KDW_ZERO_PAD_EN
      for (int i = 0; i < N_CH; i++) begin
         if ((bus.rd_addr > ext_row[bank_ptr]) ||
             ((bus.rd_addr == ext_row[bank_ptr]) &&
              (LW'(i) > ext_lane[bank_ptr]))) begin
            rd_next[i*WG_W +: WG_W] = '0;
         end
      end
`endif
   end

   // bank_ptr is the pre-swap value here, so a read issued together
   // with a swap still returns the old tile
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            bus.rd_data <= rd_next;
         end
      end
   end

endmodule

// File: tb/tb_kdw_tile_buffer.sv
// Self-checking bench for kdw_tile_buffer: directed steps plus random traffic,
// checked against a flat-array tile model of the load/swap/read rules.
module tb_kdw_tile_buffer;
   localparam int WG_W  = 8;
   localparam int N_CH  = 4;
   localparam int DEPTH = 9;
   localparam int NEL   = DEPTH * N_CH;
   localparam int RW    = N_CH * WG_W;
`ifdef KDW_ZERO_PAD_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   kdw_tile_buffer_if #(.WG_W(WG_W), .N_CH(N_CH), .DEPTH(DEPTH)) bus ();

   kdw_tile_buffer #(.WG_W(WG_W), .N_CH(N_CH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: 0 idle, 1 loading, 2 tile complete
   int            m_state;
   int            m_beats;
   int            m_n;
   int            m_rd_n;
   bit            m_ok;
   logic [7:0]    m_fill [NEL];
   logic [7:0]    m_rd   [NEL];
   logic [RW-1:0] m_rdat;
   bit            m_rk;

   function automatic logic [RW-1:0] mrow(int r);
      logic [RW-1:0] v;
      v = '0;
      if (r < DEPTH) begin
         for (int i = 0; i < N_CH; i++) begin
            if (r * N_CH + i < m_rd_n) v[i*WG_W +: WG_W] = m_rd[r*N_CH+i];
         end
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_beats = 0;
      m_n     = NEL;
      m_rd_n  = NEL;
      m_ok    = 1'b0;
      m_rdat  = '0;
      m_rk    = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".ld_ready"}, bus.ld_ready, 0);
      chk({tag, ".fill_full"}, bus.fill_full, 0);
      chk({tag, ".swap_err"}, bus.swap_err, 0);
      chk({tag, ".rd_bank_ok"}, bus.rd_bank_ok, 0);
      chk({tag, ".rd_valid"}, bus.rd_valid, 0);
      chk({tag, ".rd_data"}, bus.rd_data, 0);
   endtask

   task automatic idle_inputs();
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.ld_last  = 1'b0;
      bus.swap     = 1'b0;
      bus.rd_en    = 1'b0;
      bus.rd_addr  = '0;
   endtask

   // one clock: predict from current inputs, advance, compare
   task automatic tick();
      bit  ev;
      bit  eerr;
      int  ra;
      ev   = bus.rd_en;
      eerr = bus.swap && (m_state != 2);
      ra   = int'(bus.rd_addr);
      if (bus.rd_en) begin
         if (ra >= DEPTH) begin
            m_rdat = '0;
            m_rk   = 1'b1;
         end else if (m_ok) begin
            m_rdat = mrow(ra);
            m_rk   = 1'b1;
         end else begin
            m_rk = 1'b0;
         end
      end
      if (m_state == 2 && bus.swap) begin
         m_rd    = m_fill;
         m_rd_n  = m_n;
         m_ok    = 1'b1;
         m_state = 0;
      end else if (m_state == 0 && bus.ld_start) begin
         m_state = 1;
      end else if (m_state == 1 && bus.ld_valid) begin
         m_fill[m_beats] = bus.ld_data;
         m_beats++;
         if (m_beats == NEL || (ZP && bus.ld_last)) begin
            m_n     = m_beats;
            m_beats = 0;
            m_state = 2;
         end
      end
      @(posedge clk);
      #1;
      chk("ld_ready", bus.ld_ready, m_state == 1);
      chk("fill_full", bus.fill_full, m_state == 2);
      chk("swap_err", bus.swap_err, eerr);
      chk("rd_bank_ok", bus.rd_bank_ok, m_ok);
      chk("rd_valid", bus.rd_valid, ev);
      if (m_rk) chk("rd_data", bus.rd_data, m_rdat);
   endtask

   task automatic beat(input logic [7:0] d, input bit last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
   endtask

   task automatic pulse_start();
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
   endtask

   task automatic pulse_swap();
      bus.swap = 1'b1;
      tick();
      bus.swap = 1'b0;
   endtask

   task automatic read_rows(input int last_row);
      for (int r = 0; r <= last_row; r++) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = 4'(r);
         tick();
      end
      bus.rd_en = 1'b0;
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      // early swap mid-load, then complete tile of k=0..35
      pulse_start();
      for (int k = 0; k < 20; k++) beat(8'(k), 1'b0);
      pulse_swap();
      tick();
      for (int k = 20; k < NEL; k++) beat(8'(k), 1'b0);
      tick();
      pulse_swap();
      read_rows(DEPTH);

      // load tile B while reading tile A, then swap together with a read
      pulse_start();
      for (int k = 0; k < NEL; k++) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = 4'($urandom_range(0, DEPTH - 1));
         beat(8'($urandom), 1'b0);
      end
      bus.rd_en   = 1'b1;
      bus.rd_addr = 4'd5;
      pulse_swap();
      read_rows(DEPTH - 1);

      // gapped loader: one beat in three cycles
      pulse_start();
      for (int k = 0; k < NEL; k++) begin
         beat(8'($urandom), 1'b0);
         tick();
         tick();
      end
      pulse_swap();
      read_rows(DEPTH - 1);

      // async reset in the middle of a load
      pulse_start();
      for (int k = 0; k < 16; k++) beat(8'($urandom), 1'b0);
      bus.ld_valid = 1'b1;
      bus.rd_en    = 1'b1;
      rst_n        = 1'b0;
      #1;
      chk_zero("async_rst");
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      pulse_start();
      for (int k = 0; k < NEL; k++) beat(8'($urandom), 1'b0);
      pulse_swap();
      read_rows(DEPTH);

`ifdef KDW_ZERO_PAD_EN
      // short tile ended on row 2 lane 1
      pulse_start();
      for (int k = 0; k < 10; k++) beat(8'($urandom), k == 9);
      pulse_swap();
      read_rows(DEPTH);
`endif

      // random traffic
      for (int c = 0; c < 600; c++) begin
         bus.ld_start = ($urandom_range(0, 7) == 0);
         bus.ld_valid = $urandom_range(0, 1) == 1;
         bus.ld_data  = 8'($urandom);
         bus.ld_last  = ($urandom_range(0, 11) == 0);
         bus.swap     = ($urandom_range(0, 19) == 0);
         bus.rd_en    = $urandom_range(0, 1) == 1;
         bus.rd_addr  = 4'($urandom_range(0, 15));
         tick();
      end
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
